// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: cell encoding, board layout, controller states.
package ttt_pkg;

   localparam int BOARD_W = 18;

   localparam logic [1:0] CELL_HUMAN = 2'd0;
   localparam logic [1:0] CELL_CPU   = 2'd1;
   localparam logic [1:0] CELL_EMPTY = 2'd2;
   localparam logic [1:0] WIN_DRAW   = 2'd2;

   localparam logic [BOARD_W-1:0] BOARD_EMPTY = {9{CELL_EMPTY}};

   typedef enum logic [2:0] {
      IDLE,
      PLAYER_WAIT,
      CPU_REQ,
      CPU_WAIT,
      CHECK,
      DONE
   } state_t;

   // Indices above 8 return the unused code 3 so they never look empty.
   function automatic logic [1:0] cell_at(input logic [BOARD_W-1:0] b, input logic [3:0] idx);
      logic [1:0] c;
      c = 2'd3;
      for (int i = 0; i < 9; i++) begin
         if (idx == 4'(i)) c = b[2*i +: 2];
      end
      return c;
   endfunction

endpackage

// File: rtl/win_detector.sv
// Combinational three-in-line and board-full detector for one player code.
module win_detector
   import ttt_pkg::*;
(
   input  logic [BOARD_W-1:0] board,
   input  logic [1:0]         player,
   output logic               win,
   output logic               full
);

   logic [8:0] own;
   logic [8:0] empty;

   always_comb begin
      own   = '0;
      empty = '0;
      for (int i = 0; i < 9; i++) begin
         own[i]   = (board[2*i +: 2] == player);
         empty[i] = (board[2*i +: 2] == CELL_EMPTY);
      end
   end

   assign win = (own[0] & own[1] & own[2]) |
                (own[3] & own[4] & own[5]) |
                (own[6] & own[7] & own[8]) |
                (own[0] & own[3] & own[6]) |
                (own[1] & own[4] & own[7]) |
                (own[2] & own[5] & own[8]) |
                (own[0] & own[4] & own[8]) |
                (own[2] & own[4] & own[6]);

   assign full = ~|empty;

endmodule

// File: rtl/board_controller.sv
// Tic-tac-toe game sequencer: owns the board, alternates human and CPU moves,
// applies a fallback CPU move on timeout and reports win/draw.
module board_controller
   import ttt_pkg::*;
#(
   parameter bit CPU_FIRST   = 1'b0,
   parameter int CPU_TIMEOUT = 16
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               start,
   input  logic               player_valid,
   input  logic [3:0]         player_idx,
   output logic               player_ready,
   output logic               cpu_req,
   input  logic               cpu_valid,
   input  logic [3:0]         cpu_idx,
   output logic [BOARD_W-1:0] board,
   output logic               cpu_turn,
   output logic               illegal_move,
   output logic               game_over,
   output logic [1:0]         winner
);

   localparam int CNT_W = $clog2(CPU_TIMEOUT + 1);

   state_t             state, state_nxt;
   logic [BOARD_W-1:0] board_q, board_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [1:0]         mover, mover_nxt;
   logic               illegal_q, illegal_nxt;
   logic               over_q, over_nxt;
   logic [1:0]         winner_q, winner_nxt;

   logic               we;
   logic [3:0]         widx;
   logic [3:0]         fallback_idx;
   logic               player_legal, cpu_legal;
   logic               line_win, board_full;

   win_detector u_win (
      .board  (board_q),
      .player (mover),
      .win    (line_win),
      .full   (board_full)
   );

   assign player_legal = (player_idx <= 4'd8) && (cell_at(board_q, player_idx) == CELL_EMPTY);
   assign cpu_legal    = (cpu_idx    <= 4'd8) && (cell_at(board_q, cpu_idx)    == CELL_EMPTY);

   // Lowest-index empty cell; scanning downward leaves the smallest match.
   always_comb begin
      fallback_idx = 4'd0;
      for (int i = 8; i >= 0; i--) begin
         if (board_q[2*i +: 2] == CELL_EMPTY) fallback_idx = 4'(i);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      we          = 1'b0;
      widx        = 4'd0;
      cnt_nxt     = cnt;
      mover_nxt   = mover;
      illegal_nxt = 1'b0;
      over_nxt    = over_q;
      winner_nxt  = winner_q;
      board_nxt   = board_q;

      if (start) begin
         state_nxt  = CPU_FIRST ? CPU_REQ : PLAYER_WAIT;
         board_nxt  = BOARD_EMPTY;
         over_nxt   = 1'b0;
         winner_nxt = WIN_DRAW;
      end else begin
         case (state)
            PLAYER_WAIT: begin
               if (player_valid) begin
                  if (player_legal) begin
                     we        = 1'b1;
                     widx      = player_idx;
                     mover_nxt = CELL_HUMAN;
                     state_nxt = CHECK;
                  end else begin
                     illegal_nxt = 1'b1;
                  end
               end
            end
            CPU_REQ: begin
               cnt_nxt   = '0;
               state_nxt = CPU_WAIT;
            end
            CPU_WAIT: begin
               if (cpu_valid && cpu_legal) begin
                  we        = 1'b1;
                  widx      = cpu_idx;
                  mover_nxt = CELL_CPU;
                  state_nxt = CHECK;
               end else begin
                  illegal_nxt = cpu_valid;
                  // A rejected CPU move does not restart the timeout window.
                  if (cnt == CNT_W'(CPU_TIMEOUT - 1)) begin
                     we        = 1'b1;
                     widx      = fallback_idx;
                     mover_nxt = CELL_CPU;
                     state_nxt = CHECK;
                  end else begin
                     cnt_nxt = cnt + 1'b1;
                  end
               end
            end
            CHECK: begin
               if (line_win) begin
                  state_nxt  = DONE;
                  over_nxt   = 1'b1;
                  winner_nxt = mover;
               end else if (board_full) begin
                  state_nxt  = DONE;
                  over_nxt   = 1'b1;
                  winner_nxt = WIN_DRAW;
               end else begin
                  state_nxt = (mover == CELL_CPU) ? PLAYER_WAIT : CPU_REQ;
               end
            end
            default: ;
         endcase

         if (we) begin
            for (int i = 0; i < 9; i++) begin
               if (widx == 4'(i)) board_nxt[2*i +: 2] = mover_nxt;
            end
         end
      end
   end

   always_comb begin
      player_ready = (state == PLAYER_WAIT);
      cpu_req      = (state == CPU_REQ);
      cpu_turn     = (state == CPU_REQ) || (state == CPU_WAIT);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         board_q   <= BOARD_EMPTY;
         cnt       <= '0;
         mover     <= CELL_HUMAN;
         illegal_q <= 1'b0;
         over_q    <= 1'b0;
         winner_q  <= WIN_DRAW;
      end else begin
         board_q   <= board_nxt;
         cnt       <= cnt_nxt;
         mover     <= mover_nxt;
         illegal_q <= illegal_nxt;
         over_q    <= over_nxt;
         winner_q  <= winner_nxt;
      end
   end

   assign board        = board_q;
   assign illegal_move = illegal_q;
   assign game_over    = over_q;
   assign winner       = winner_q;

endmodule
